// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq: registered ALU stage between register-file read and writeback.
//
// This stage keeps the NZCV flag register inside itself. An instruction is
// accepted on the in_valid/in_ready handshake. Its result is then held on
// the out_valid/out_ready handshake until the consumer takes it.
//
// Features:
//   - Pre-op shifter on operand B (LSL/LSR/ASR/ROR by imvalue[SH_W-1:0]).
//   - ARM-style condition codes, evaluated against the flag register as it
//     stands at the acceptance edge.
//   - Single-cycle ops: latency 1. A MUL whose condition passes runs a
//     W-iteration shift-add loop and completes on the W-th edge after
//     acceptance.
//
// Ports:
//   clk, rst              rising-edge clock, async active-high reset
//   in_valid / in_ready   issue handshake
//   opcode, cond, s       operation, condition code, update-flags
//   srctrl                shifter control for operand B
//   in1, in2              operands A and B
//   imvalue               immediate (zero-extended); low SH_W bits = shift amount
//   flags_wr, flags_in    direct load of the flag register {N,Z,C,V}
//   out_valid / out_ready result handshake
//   result, executed      held result and condition-passed indication
//   outflags              current flag register {N,Z,C,V}
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int W     = 32,
    parameter int IMM_W = 16,
    parameter int SH_W  = $clog2(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [3:0]       cond,
    input  logic             s,
    input  logic [2:0]       srctrl,
    input  logic [W-1:0]     in1,
    input  logic [W-1:0]     in2,
    input  logic [IMM_W-1:0] imvalue,
    input  logic             flags_wr,
    input  logic [3:0]       flags_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     result,
    output logic             executed,
    output logic [3:0]       outflags
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_MOV  = 4'd6;
    localparam logic [3:0] OP_MOVI = 4'd7;
    localparam logic [3:0] OP_CMP  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;

    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

    // Working state of the iterative multiplier.
    typedef struct packed {
        logic [W-1:0]    acc;
        logic [W-1:0]    mcand;
        logic [W-1:0]    mplier;
        logic [SH_W-1:0] cnt;
        logic            s;
    } mul_ctx_t;

    state_t          state_q, state_d;
    logic [3:0]      flags_q, flags_d;
    mul_ctx_t        mul_q;
    logic [W-1:0]    result_q;
    logic            executed_q;
    logic            out_valid_q;

    logic            fn, fz, fc, fv;
    logic [SH_W-1:0] amt;
    logic [2*W-1:0]  rot;
    logic [W-1:0]    opb;
    logic [W-1:0]    imm_z;
    logic            cond_ok;
    logic            accept;
    logic            mul_go;
    logic            mul_last;
    logic [W-1:0]    acc_nxt;

    logic            sub_op;
    logic [W-1:0]    addend;
    logic [W:0]      sum;
    logic            ovf;
    logic [W-1:0]    alu_res;
    logic            arith;
    logic            nz_op;
    logic            single_commit;

    assign {fn, fz, fc, fv} = flags_q;
    assign amt   = imvalue[SH_W-1:0];
    assign imm_z = W'(imvalue);

    // ------------------------------------------------------------------
    // Operand B shifter. ROR comes from the low half of a doubled word
    // shifted right, so it needs no W-amt subtraction.
    // ------------------------------------------------------------------
    assign rot = {in2, in2} >> amt;

    always_comb begin
        opb = in2;
        if (amt != '0) begin
            case (srctrl)
                3'd1:    opb = in2 << amt;
                3'd2:    opb = in2 >> amt;
                3'd3:    opb = $signed(in2) >>> amt;
                3'd4:    opb = rot[W-1:0];
                default: opb = in2;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Condition evaluation against the current flag register.
    // ------------------------------------------------------------------
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'd0:  cond_ok = 1'b1;
            4'd1:  cond_ok = fz;
            4'd2:  cond_ok = ~fz;
            4'd3:  cond_ok = fc;
            4'd4:  cond_ok = ~fc;
            4'd5:  cond_ok = fn;
            4'd6:  cond_ok = ~fn;
            4'd7:  cond_ok = fv;
            4'd8:  cond_ok = ~fv;
            4'd9:  cond_ok = fc & ~fz;
            4'd10: cond_ok = ~fc | fz;
            4'd11: cond_ok = (fn == fv);
            4'd12: cond_ok = (fn != fv);
            4'd13: cond_ok = ~fz & (fn == fv);
            4'd14: cond_ok = fz | (fn != fv);
            default: cond_ok = 1'b0;
        endcase
    end

    assign in_ready = (state_q != MUL) & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    // A failed-condition MUL takes the single-cycle path and returns 0.
    assign mul_go   = accept & (opcode == OP_MUL) & cond_ok;
    assign mul_last = (state_q == MUL) && (mul_q.cnt == SH_W'(W - 1));
    assign acc_nxt  = mul_q.acc + (mul_q.mplier[0] ? mul_q.mcand : '0);

    // ------------------------------------------------------------------
    // Single-cycle datapath. SUB/CMP run as A + ~B' + 1, so the carry-out
    // means "no borrow".
    // ------------------------------------------------------------------
    assign sub_op = (opcode == OP_SUB) || (opcode == OP_CMP);
    assign addend = sub_op ? ~opb : opb;
    assign sum    = {1'b0, in1} + {1'b0, addend} + {{W{1'b0}}, sub_op};
    assign ovf    = (in1[W-1] == addend[W-1]) & (sum[W-1] != in1[W-1]);

    always_comb begin
        alu_res = '0;
        arith   = 1'b0;
        nz_op   = 1'b1;
        case (opcode)
            OP_ADD, OP_SUB, OP_CMP: begin
                alu_res = sum[W-1:0];
                arith   = 1'b1;
            end
            OP_AND:  alu_res = in1 & opb;
            OP_OR:   alu_res = in1 | opb;
            OP_XOR:  alu_res = in1 ^ opb;
            OP_NOT:  alu_res = ~opb;
            OP_MOV:  alu_res = opb;
            OP_MOVI: alu_res = imm_z;
            // MUL flags come from the iterative path; reserved ops leave flags alone.
            default: nz_op = 1'b0;
        endcase
    end

    assign single_commit = accept & cond_ok & nz_op & (s | (opcode == OP_CMP));

    // Flag next-state. A direct load goes in first. An ALU commit on the
    // same edge then overwrites only the fields that the op defines.
    always_comb begin
        flags_d = flags_wr ? flags_in : flags_q;
        if (single_commit) begin
            flags_d[3] = alu_res[W-1];
            flags_d[2] = ~|alu_res;
            if (arith) flags_d[1:0] = {sum[W], ovf};
        end else if (mul_last && mul_q.s) begin
            flags_d[3] = acc_nxt[W-1];
            flags_d[2] = ~|acc_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, HOLD: begin
                if (accept)
                    state_d = mul_go ? MUL : HOLD;
                else if (state_q == HOLD && out_ready)
                    state_d = IDLE;
            end
            MUL:     if (mul_last) state_d = HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            flags_q     <= '0;
            mul_q       <= '0;
            result_q    <= '0;
            executed_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;

            if (mul_go) begin
                mul_q.acc    <= '0;
                mul_q.mcand  <= in1;
                mul_q.mplier <= opb;
                mul_q.cnt    <= '0;
                mul_q.s      <= s;
            end else if (state_q == MUL) begin
                mul_q.acc    <= acc_nxt;
                mul_q.mcand  <= mul_q.mcand << 1;
                mul_q.mplier <= mul_q.mplier >> 1;
                mul_q.cnt    <= mul_q.cnt + SH_W'(1);
            end

            // Output slot. Accepting a new op consumes any held result on
            // the same edge, because in_ready already required out_ready.
            if (accept) begin
                if (mul_go) begin
                    out_valid_q <= 1'b0;
                end else begin
                    result_q    <= cond_ok ? alu_res : '0;
                    executed_q  <= cond_ok;
                    out_valid_q <= 1'b1;
                end
            end else if (mul_last) begin
                result_q    <= acc_nxt;
                executed_q  <= 1'b1;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign executed  = executed_q;
    assign outflags  = flags_q;

endmodule
